// File: rtl/motor_scheduler_if.sv
// Host command port of motor_scheduler: request/grant handshake plus the
// requested H-bridge vector and the illegal-pattern error pulse.
interface motor_scheduler_if;
  logic       cmd_req;
  logic [3:0] cmd_motor;
  logic       cmd_gnt;
  logic       cmd_err;

  modport master (
    output cmd_req,
    output cmd_motor,
    input  cmd_gnt,
    input  cmd_err
  );

  modport slave (
    input  cmd_req,
    input  cmd_motor,
    output cmd_gnt,
    output cmd_err
  );
endinterface

// File: rtl/motor_scheduler.sv
// Drive-path controller: arbitrates the H-bridge vector {IN4,IN3,IN2,IN1}
// between obstacle stop, host command port and built-in line follower, with
// input debounce, per-motor reversal dead time and PWM gating.
module motor_scheduler #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned DEADTIME   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                D1,
  input  logic                D4,
  input  logic                obs,
  input  logic [7:0]          speed,
  motor_scheduler_if.slave    cmd,
  output logic [1:0]          state,
  output logic [3:0]          motor
);

  typedef enum logic [1:0] {IDLE = 2'd0, FOLLOW = 2'd1, HOST = 2'd2, BRAKE = 2'd3} state_t;
  typedef enum logic [1:0] {OFF = 2'd0, FWD = 2'd1, REV = 2'd2} dir_t;

  // index 0 = D1, 1 = D4, 2 = obs
  logic [2:0] raw;
  logic [2:0] deb_q;
  logic [3:0] deb_cnt [3];

  state_t     state_q;
  state_t     nxt;
  logic [7:0] pwm_cnt;
  logic       pwm_on;

  // index 0 = left motor (IN1 fwd / IN2 rev), 1 = right motor (IN4 fwd / IN3 rev)
  dir_t       dir_q   [2];
  dir_t       dir_n   [2];
  dir_t       tgt_dir [2];
  logic [7:0] dt_cnt  [2];
  logic [7:0] dt_n    [2];

  logic [3:0] host_tgt;
  logic       illegal;
  logic [3:0] line_tgt;
  logic [3:0] target;
  logic [3:0] image;

  assign raw   = {obs, D4, D1};
  assign state = state_q;

  // Pin pair given as {fwd_pin, rev_pin}.
  function automatic dir_t decode(input logic [1:0] fr);
    case (fr)
      2'b10:   decode = FWD;
      2'b01:   decode = REV;
      default: decode = OFF;
    endcase
  endfunction

  // Debounce: accept a new value after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (rst) begin
        deb_q[i]   <= 1'b0;
        deb_cnt[i] <= '0;
      end else if (raw[i] == deb_q[i]) begin
        deb_cnt[i] <= '0;
      end else if (deb_cnt[i] == 4'(DEB_CYCLES - 1)) begin
        deb_q[i]   <= raw[i];
        deb_cnt[i] <= '0;
      end else begin
        deb_cnt[i] <= deb_cnt[i] + 4'd1;
      end
    end
  end

  // Next owner, targets and committed-direction update for the coming edge.
  // Motor is registered from the next state so it switches owner together with state.
  always_comb begin
    nxt = FOLLOW;
    if (!enable)                 nxt = IDLE;
    else if (deb_q[2])           nxt = BRAKE;
    else if (cmd.cmd_req)        nxt = HOST;

    host_tgt = cmd.cmd_motor;
    illegal  = 1'b0;
    if (&cmd.cmd_motor[3:2]) begin host_tgt[3:2] = '0; illegal = 1'b1; end
    if (&cmd.cmd_motor[1:0]) begin host_tgt[1:0] = '0; illegal = 1'b1; end

    case ({deb_q[0], deb_q[1]})
      2'b00:   line_tgt = 4'b1001;
      2'b01:   line_tgt = 4'b0001;
      2'b10:   line_tgt = 4'b1000;
      default: line_tgt = 4'b0000;
    endcase

    target = '0;
    if (nxt == HOST)        target = host_tgt;
    else if (nxt == FOLLOW) target = line_tgt;

    tgt_dir[0] = decode({target[0], target[1]});
    tgt_dir[1] = decode({target[3], target[2]});

    for (int unsigned m = 0; m < 2; m++) begin
      dir_n[m] = dir_q[m];
      dt_n[m]  = dt_cnt[m];
      if (nxt == IDLE || nxt == BRAKE) begin
        dir_n[m] = OFF;
        dt_n[m]  = '0;
      end else if (dt_cnt[m] != '0) begin
        // Dead time runs to expiry regardless of target changes.
        if (dt_cnt[m] == 8'd1) begin
          dir_n[m] = tgt_dir[m];
          dt_n[m]  = '0;
        end else begin
          dt_n[m]  = dt_cnt[m] - 8'd1;
        end
      end else if ((dir_q[m] == FWD && tgt_dir[m] == REV) ||
                   (dir_q[m] == REV && tgt_dir[m] == FWD)) begin
        dir_n[m] = OFF;
        dt_n[m]  = 8'(DEADTIME);
      end else begin
        dir_n[m] = tgt_dir[m];
      end
    end

    image  = {dir_n[1] == FWD, dir_n[1] == REV, dir_n[0] == REV, dir_n[0] == FWD};
    pwm_on = (speed == 8'hFF) || (pwm_cnt < speed);
  end

  // FSM, committed directions, PWM counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pwm_cnt     <= '0;
      motor       <= '0;
      cmd.cmd_gnt <= 1'b0;
      cmd.cmd_err <= 1'b0;
      for (int unsigned m = 0; m < 2; m++) begin
        dir_q[m]  <= OFF;
        dt_cnt[m] <= '0;
      end
    end else begin
      state_q     <= nxt;
      pwm_cnt     <= pwm_cnt + 8'd1;
      motor       <= pwm_on ? image : 4'b0000;
      cmd.cmd_gnt <= (nxt == HOST);
      cmd.cmd_err <= (nxt == HOST) && illegal;
      for (int unsigned m = 0; m < 2; m++) begin
        dir_q[m]  <= dir_n[m];
        dt_cnt[m] <= dt_n[m];
      end
    end
  end

endmodule
